mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single-port 32x16 MEMORY between instruction fetch (IF, read-only) and
//  the data/stack stage (D, read/write). Sequences the memory's level-triggered rd/wr
//  strobes: one-cycle strobe, then a strobe-low cycle so the memory sees a fresh
//  rd/wr event per access. Data port has priority; a starvation counter guarantees fetch progress.
// PARAMETERS
//  ADDR_W    5   memory address width
//  DATA_W    16  memory data width
//  MAX_WAIT  3   consecutive lost arbitrations after which IF wins the next one (>=1)
// PORTS
//  clk       in   1       clock, all state updates on posedge
//  rst       in   1       synchronous, active-high reset
//  if_req    in   1       fetch request; hold with if_addr until if_ack
//  if_addr   in   ADDR_W  fetch address
//  if_ack    out  1       one-cycle pulse: if_rdata valid this cycle
//  if_rdata  out  DATA_W  fetched word, held until next IF ack
//  d_req     in   1       data request; hold with d_we/d_addr/d_wdata until d_ack
//  d_we      in   1       1=write, 0=read
//  d_addr    in   ADDR_W  data address
//  d_wdata   in   DATA_W  write data
//  d_ack     out  1       one-cycle pulse: access complete (d_rdata valid if read)
//  d_rdata   out  DATA_W  read word, held until next D read ack
//  mem_addr  out  ADDR_W  to MEMORY address
//  mem_rd    out  1       to MEMORY rd
//  mem_wr    out  1       to MEMORY wr
//  mem_in    out  DATA_W  to MEMORY in
//  mem_out   in   DATA_W  from MEMORY out
//  busy      out  1       1 in ISSUE or RECOVER
//  gnt_d     out  1       owner of current/last access: 1=D, 0=IF
// BEHAVIOUR
//  Reset: state=IDLE; all outputs 0; wait counter 0. Reset in ISSUE aborts: no ack,
//   strobes low next cycle; a write may already have landed (memory is strobe-driven).
//  States: IDLE -> ISSUE -> RECOVER -> (ISSUE | IDLE). Registered outputs throughout.
//  Arbitration (in IDLE and RECOVER): candidates = pending reqs, excluding the port
//   acked this cycle (its req is ignored for that one cycle to avoid a duplicate issue).
//   D wins over IF unless wait_cnt==MAX_WAIT and IF pending, then IF wins.
//   Winner's addr/we/wdata latched into mem_addr/mem_wr/mem_in; next state ISSUE.
//   No candidate -> IDLE.
//  ISSUE: exactly one of mem_rd/mem_wr high for one cycle, mem_addr stable.
//   At end of ISSUE: read data captured from mem_out into if_rdata/d_rdata; ack
//   register set -> ack high during RECOVER. Next state RECOVER.
//  RECOVER: mem_rd=mem_wr=0; ack pulse high; arbitration as above.
//  Latency: req seen in IDLE at edge N -> strobe cycle N+1 -> ack cycle N+2.
//   Back-to-back throughput: one access per 2 cycles.
//  wait_cnt: +1 (saturating at MAX_WAIT) on each arbitration D wins while IF pending;
//   cleared when IF is granted; unchanged otherwise.
//  mem_addr/mem_in hold last value in IDLE/RECOVER; mem_in driven only from d_wdata.
//  Simultaneous req from both in IDLE with wait_cnt<MAX_WAIT: D first, IF next.
//  Dropping req before ack is a protocol violation; behaviour undefined, no checking.
// TESTING
//  1 Reset: assert rst 2 cycles mid-ISSUE -> all outputs 0, no ack, state IDLE next cycle.
//  2 IF read addr 21 alone -> mem_rd high 1 cycle N+1, if_ack at N+2, if_rdata=16'hF400.
//  3 D write addr 3 data 16'h00A5 then D read addr 3 -> mem_wr pulse, d_ack; read
//    returns 16'h00A5; mem_rd/mem_wr never high in consecutive cycles.
//  4 Both req same cycle (IF addr 22, D read addr 0) -> D acked first (d_rdata=3),
//    IF acked 2 cycles later (if_rdata=16'hF420), gnt_d 1 then 0.
//  5 D req held continuously (new addr each ack), IF pending -> IF granted on its
//    4th arbitration (MAX_WAIT=3), wait_cnt returns to 0.
//  6 Port re-asserts req in ack cycle -> no duplicate strobe; new access issues
//    following arbitration, every ack matches exactly one strobe.

Source files
------------

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one single-port memory between instruction fetch (IF,
//            read-only) and the data/stack stage (D, read/write). Each access
//            is a one-cycle rd/wr strobe followed by a strobe-low recovery
//            cycle, so the level-triggered memory sees a fresh event per
//            access. D has priority; a wait counter lets IF win after
//            MAX_WAIT consecutive losses.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 16,
  parameter int MAX_WAIT = 3
) (
  input  logic              clk,
  input  logic              rst,
  // instruction fetch port
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_ack_o,
  output logic [DATA_W-1:0] if_rdata_o,
  // data port
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic              d_ack_o,
  output logic [DATA_W-1:0] d_rdata_o,
  // memory side
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_rd_o,
  output logic              mem_wr_o,
  output logic [DATA_W-1:0] mem_in_o,
  input  logic [DATA_W-1:0] mem_out_i,
  // status
  output logic              busy_o,
  output logic              gnt_d_o
);

  localparam int WAIT_W = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_RECOVER = 2'd2
  } state_t;

  state_t              state_q;
  logic [WAIT_W-1:0]   wait_cnt_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic                mem_rd_q;
  logic                mem_wr_q;
  logic [DATA_W-1:0]   mem_in_q;
  logic                if_ack_q;
  logic                d_ack_q;
  logic [DATA_W-1:0]   if_rdata_q;
  logic [DATA_W-1:0]   d_rdata_q;
  logic                busy_q;
  logic                gnt_d_q;

  logic                cand_if_d;
  logic                cand_d_d;
  logic                if_wins_d;
  logic                d_wins_d;

  // Arbitration: a port acked this cycle is not a candidate, so a request
  // re-asserted in the ack cycle is not issued twice. Acks are only high in
  // RECOVER, so in IDLE the masking has no effect.
  always_comb begin
    cand_if_d = if_req_i & ~if_ack_q;
    cand_d_d  = d_req_i  & ~d_ack_q;
    if_wins_d = cand_if_d & (~cand_d_d | (wait_cnt_q == WAIT_MAX));
    d_wins_d  = cand_d_d & ~if_wins_d;
  end

  // Access sequencer: IDLE -> ISSUE -> RECOVER -> (ISSUE | IDLE), all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      wait_cnt_q <= '0;
      mem_addr_q <= '0;
      mem_rd_q   <= 1'b0;
      mem_wr_q   <= 1'b0;
      mem_in_q   <= '0;
      if_ack_q   <= 1'b0;
      d_ack_q    <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      busy_q     <= 1'b0;
      gnt_d_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_RECOVER: begin
          if_ack_q <= 1'b0;
          d_ack_q  <= 1'b0;
          mem_rd_q <= 1'b0;
          mem_wr_q <= 1'b0;
          if (d_wins_d) begin
            state_q    <= S_ISSUE;
            busy_q     <= 1'b1;
            gnt_d_q    <= 1'b1;
            mem_addr_q <= d_addr_i;
            mem_in_q   <= d_wdata_i;
            mem_wr_q   <= d_we_i;
            mem_rd_q   <= ~d_we_i;
            // IF lost an arbitration it took part in
            if (cand_if_d && (wait_cnt_q != WAIT_MAX)) begin
              wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
            end
          end else if (if_wins_d) begin
            state_q    <= S_ISSUE;
            busy_q     <= 1'b1;
            gnt_d_q    <= 1'b0;
            mem_addr_q <= if_addr_i;
            mem_rd_q   <= 1'b1;
            wait_cnt_q <= '0;
          end else begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        S_ISSUE: begin
          // strobe ends; memory output is valid for the whole strobe cycle
          state_q  <= S_RECOVER;
          busy_q   <= 1'b1;
          mem_rd_q <= 1'b0;
          mem_wr_q <= 1'b0;
          if (gnt_d_q) begin
            d_ack_q <= 1'b1;
            if (!mem_wr_q) begin
              d_rdata_q <= mem_out_i;
            end
          end else begin
            if_ack_q   <= 1'b1;
            if_rdata_q <= mem_out_i;
          end
        end
        default: begin
          state_q  <= S_IDLE;
          busy_q   <= 1'b0;
          mem_rd_q <= 1'b0;
          mem_wr_q <= 1'b0;
          if_ack_q <= 1'b0;
          d_ack_q  <= 1'b0;
        end
      endcase
    end
  end

  assign if_ack_o   = if_ack_q;
  assign if_rdata_o = if_rdata_q;
  assign d_ack_o    = d_ack_q;
  assign d_rdata_o  = d_rdata_q;
  assign mem_addr_o = mem_addr_q;
  assign mem_rd_o   = mem_rd_q;
  assign mem_wr_o   = mem_wr_q;
  assign mem_in_o   = mem_in_q;
  assign busy_o     = busy_q;
  assign gnt_d_o    = gnt_d_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Self-checking bench for mem_port_arbiter. Expected behaviour is
//            computed per clock edge from grant times: an access granted at
//            edge g strobes after edge g, acks after edge g+1, and the next
//            arbitration is at edge g+2 with the just-served port excluded.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

  localparam int AW = 5;
  localparam int DW = 16;
  localparam int MW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_ack;
  logic [DW-1:0] if_rdata;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_ack;
  logic [DW-1:0] d_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_rd;
  logic          mem_wr;
  logic [DW-1:0] mem_in;
  logic [DW-1:0] mem_out;
  logic          busy;
  logic          gnt_d;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_ack_o(if_ack), .if_rdata_o(if_rdata),
    .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
    .d_ack_o(d_ack), .d_rdata_o(d_rdata),
    .mem_addr_o(mem_addr), .mem_rd_o(mem_rd), .mem_wr_o(mem_wr), .mem_in_o(mem_in),
    .mem_out_i(mem_out), .busy_o(busy), .gnt_d_o(gnt_d)
  );

  always #5 clk = ~clk;

  // Memory: asynchronous read, write lands at the edge ending the wr strobe.
  logic [DW-1:0] mem_arr [32];
  assign mem_out = mem_arr[mem_addr];
  always @(posedge clk) if (mem_wr) mem_arr[mem_addr] <= mem_in;

  // DUT strobe/ack activity, counted mid-cycle.
  int dut_strobes = 0;
  int dut_acks    = 0;
  always @(negedge clk) begin
    if (mem_rd === 1'b1 || mem_wr === 1'b1) dut_strobes++;
    if (if_ack === 1'b1 || d_ack === 1'b1)  dut_acks++;
  end

  // Reference model state
  logic [DW-1:0] ref_mem [32];
  int            edge_n = 0;
  int            g_edge = -10;
  bit            g_d, g_we;
  logic [AW-1:0] g_addr;
  logic [DW-1:0] g_wdata;
  int            wait_m = 0;
  logic [DW-1:0] e_if_rdata, e_d_rdata, e_mem_in;
  logic [AW-1:0] e_mem_addr;
  bit            e_gnt_d;
  int            m_strobes = 0;
  int            m_acks    = 0;

  int  checks   = 0;
  int  failures = 0;
  bit  rnd_mode = 0;
  bit  d_hold   = 0;
  bit  if_hold  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance the model by one clock edge using the inputs present at that edge.
  task automatic model_edge();
    bit c_if, c_d, ex_if, ex_d;
    edge_n++;
    if (edge_n == g_edge + 1) begin
      // strobe cycle ends at this edge; a write lands even if reset is high
      if (g_we) ref_mem[g_addr] = g_wdata;
      else if (!rst) begin
        if (g_d) e_d_rdata = ref_mem[g_addr];
        else     e_if_rdata = ref_mem[g_addr];
      end
      if (!rst) m_acks++;
    end
    if (rst) begin
      g_edge = -10; wait_m = 0; e_gnt_d = 0;
      e_if_rdata = '0; e_d_rdata = '0; e_mem_in = '0; e_mem_addr = '0;
      return;
    end
    if (edge_n >= g_edge + 2) begin
      ex_if = (edge_n == g_edge + 2) && !g_d;
      ex_d  = (edge_n == g_edge + 2) &&  g_d;
      c_if  = if_req && !ex_if;
      c_d   = d_req && !ex_d;
      if (c_if && (!c_d || wait_m == MW)) begin
        g_edge = edge_n; g_d = 0; g_we = 0; g_addr = if_addr;
        wait_m = 0;
        e_mem_addr = if_addr; e_gnt_d = 0; m_strobes++;
      end else if (c_d) begin
        g_edge = edge_n; g_d = 1; g_we = d_we; g_addr = d_addr; g_wdata = d_wdata;
        if (c_if && wait_m < MW) wait_m++;
        e_mem_addr = d_addr; e_mem_in = d_wdata; e_gnt_d = 1; m_strobes++;
      end
    end
  endtask

  // One clock: update model, compare mid-cycle, then masters react.
  task automatic step();
    bit x_ifack, x_dack;
    @(posedge clk);
    model_edge();
    #1;
    x_ifack = (edge_n == g_edge + 1) && !g_d;
    x_dack  = (edge_n == g_edge + 1) &&  g_d;
    chk("mem_rd",   mem_rd,   (edge_n == g_edge) && !g_we);
    chk("mem_wr",   mem_wr,   (edge_n == g_edge) &&  g_we);
    chk("if_ack",   if_ack,   x_ifack);
    chk("d_ack",    d_ack,    x_dack);
    chk("busy",     busy,     (edge_n == g_edge) || (edge_n == g_edge + 1));
    chk("gnt_d",    gnt_d,    e_gnt_d);
    chk("mem_addr", mem_addr, e_mem_addr);
    chk("mem_in",   mem_in,   e_mem_in);
    chk("if_rdata", if_rdata, e_if_rdata);
    chk("d_rdata",  d_rdata,  e_d_rdata);
    if (x_ifack) if_req = 0;
    if (x_dack)  d_req  = 0;
    if ((if_hold || (rnd_mode && $urandom_range(0, 2) != 0)) && !if_req) begin
      if_req = 1; if_addr = AW'($urandom);
    end
    if ((d_hold || (rnd_mode && $urandom_range(0, 2) != 0)) && !d_req) begin
      d_req = 1; d_we = 1'($urandom); d_addr = AW'($urandom); d_wdata = DW'($urandom);
    end
    if (rnd_mode) rst = ($urandom_range(0, 39) == 0);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem_arr[i] = DW'($urandom);
    mem_arr[0]  = 16'h0003;
    mem_arr[21] = 16'hF400;
    mem_arr[22] = 16'hF420;
    for (int i = 0; i < 32; i++) ref_mem[i] = mem_arr[i];
    rst = 1; if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_addr = '0; d_wdata = '0;

    // Reset state
    run(2);
    chk("rst_busy", busy, 0);
    chk("rst_strobe", mem_rd | mem_wr, 0);
    chk("rst_mem_addr", mem_addr, 0);
    rst = 0;
    run(1);

    // Reset during ISSUE aborts the access
    d_req = 1; d_we = 0; d_addr = 5'd5;
    step();
    chk("t1_issue_rd", mem_rd, 1);
    rst = 1; d_req = 0;
    step();
    chk("t1_no_ack", d_ack | if_ack, 0);
    step();
    chk("t1_busy", busy, 0);
    rst = 0;
    run(2);

    // IF read alone: strobe at N+1, ack at N+2
    if_req = 1; if_addr = 5'd21;
    step();
    chk("t2_strobe", mem_rd, 1);
    step();
    chk("t2_ack", if_ack, 1);
    chk("t2_rdata", if_rdata, 16'hF400);
    run(2);

    // D write then read back
    d_req = 1; d_we = 1; d_addr = 5'd3; d_wdata = 16'h00A5;
    run(3);
    d_req = 1; d_we = 0; d_addr = 5'd3;
    run(3);
    chk("t3_rdata", d_rdata, 16'h00A5);

    // Simultaneous requests: D first, IF two cycles later
    if_req = 1; if_addr = 5'd22;
    d_req = 1; d_we = 0; d_addr = 5'd0;
    step();
    chk("t4_gnt_d", gnt_d, 1);
    step();
    chk("t4_dack", d_ack, 1);
    chk("t4_drdata", d_rdata, 16'h0003);
    step();
    chk("t4_gnt_if", gnt_d, 0);
    step();
    chk("t4_ifack", if_ack, 1);
    chk("t4_ifrdata", if_rdata, 16'hF420);
    run(2);

    // D held continuously with new requests each ack; IF must still progress
    d_hold = 1;
    if_req = 1; if_addr = 5'd21;
    run(12);
    chk("t5_if_served", if_req, 0);
    // Both ports re-request in their ack cycles
    if_hold = 1;
    run(16);
    d_hold = 0; if_hold = 0;
    run(4);

    // Randomized traffic with occasional resets
    rnd_mode = 1;
    run(400);
    rnd_mode = 0; rst = 0; if_req = 0; d_req = 0;
    run(6);

    chk("strobe_count", dut_strobes, m_strobes);
    chk("ack_count", dut_acks, m_acks);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
